// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-channel pushbutton synchronizer, debounce FSM and optional auto-repeat
// Each channel debounces active-low KEY into key_level plus one-cycle press/release pulses.
module key_debounce #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 250000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic         CLOCK_50,
  input  logic         Resetn,
  input  logic [N-1:0] KEY,
  output logic [N-1:0] key_level,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release
);

  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DBW-1:0] DB_TERM = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  RD_TERM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]  RP_TERM = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;

  logic [N-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  state_t         state_q     [N];
  state_t         state_d     [N];
  logic [DBW-1:0] cnt_q       [N];
  logic [DBW-1:0] cnt_d       [N];
  logic [RW-1:0]  rep_cnt_q   [N];
  logic [RW-1:0]  rep_cnt_d   [N];
  logic [N-1:0]   rep_first_q, rep_first_d;
  logic [N-1:0]   key_level_q, key_level_d;
  logic [N-1:0]   key_press_q, key_press_d;
  logic [N-1:0]   key_release_q, key_release_d;
  logic [N-1:0]   held_q, held_d, accept_press, rep_fire;

  always_comb begin
    sync1_d       = KEY;
    sync2_d       = sync1_q;
    rep_first_d   = rep_first_q;
    key_level_d   = '0;
    key_press_d   = '0;
    key_release_d = '0;
    held_q        = '0;
    held_d        = '0;
    accept_press  = '0;
    rep_fire      = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      // sync2_q is active-low: 0 means the button is currently pressed
      case (state_q[i])
        IDLE: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT_PRESS;
            cnt_d[i]   = '0;
          end
        end
        WAIT_PRESS: begin
          if (sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_TERM) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + DBW'(1);
          end
        end
        PRESSED: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT_RELEASE;
            cnt_d[i]   = '0;
          end
        end
        WAIT_RELEASE: begin
          if (!sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_TERM) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + DBW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase

      held_q[i]       = (state_q[i] == PRESSED) || (state_q[i] == WAIT_RELEASE);
      held_d[i]       = (state_d[i] == PRESSED) || (state_d[i] == WAIT_RELEASE);
      accept_press[i] = (state_q[i] == WAIT_PRESS) && (state_d[i] == PRESSED);

      // Repeats only fire while the key stays held, so a release-accept cycle never doubles up
      if (REPEAT_EN != 0) begin
        if (accept_press[i]) begin
          rep_cnt_d[i]   = '0;
          rep_first_d[i] = 1'b1;
        end else if (held_q[i] && held_d[i]) begin
          if (rep_cnt_q[i] == (rep_first_q[i] ? RD_TERM : RP_TERM)) begin
            rep_fire[i]    = 1'b1;
            rep_cnt_d[i]   = '0;
            rep_first_d[i] = 1'b0;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + RW'(1);
          end
        end else begin
          rep_cnt_d[i]   = '0;
          rep_first_d[i] = 1'b0;
        end
      end else begin
        rep_cnt_d[i]   = '0;
        rep_first_d[i] = 1'b0;
      end

      key_level_d[i]   = held_d[i];
      key_press_d[i]   = accept_press[i] || rep_fire[i];
      key_release_d[i] = (state_q[i] == WAIT_RELEASE) && (state_d[i] == IDLE);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      rep_first_q   <= '0;
      key_level_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i]   <= IDLE;
        cnt_q[i]     <= '0;
        rep_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      rep_first_q   <= rep_first_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      for (int i = 0; i < N; i++) begin
        state_q[i]   <= state_d[i];
        cnt_q[i]     <= cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  assign key_level   = key_level_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed bench for key_debounce with and without auto-repeat
module tb_key_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] level, press, release_p;
  logic [3:0] r_level, r_press, r_release;
  int         checks;
  int         failures;

  key_debounce #(.N(4), .DB_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
    .CLOCK_50(clk), .Resetn(rst_n), .KEY(key),
    .key_level(level), .key_press(press), .key_release(release_p)
  );

  key_debounce #(.N(4), .DB_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_rep (
    .CLOCK_50(clk), .Resetn(rst_n), .KEY(key),
    .key_level(r_level), .key_press(r_press), .key_release(r_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    key      = 4'hF;
    rst_n    = 1'b0;
    #3;
    check("reset_level", 32'(level), 32'h0);
    check("reset_press", 32'(press), 32'h0);
    check("reset_release", 32'(release_p), 32'h0);
    step(); step(); step();
    rst_n = 1'b1;
    repeat (5) step();

    // clean press on channel 0
    key[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("press0_early_level", 32'(level), 32'h0);
      check("press0_early_press", 32'(press), 32'h0);
    end
    step();
    check("press0_level", 32'(level), 32'h1);
    check("press0_pulse", 32'(press), 32'h1);
    check("press0_norel", 32'(release_p), 32'h0);
    step();
    check("press0_pulse_gone", 32'(press), 32'h0);
    check("press0_level_hold", 32'(level), 32'h1);

    // release on channel 0
    key[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("rel0_early_level", 32'(level), 32'h1);
      check("rel0_early_release", 32'(release_p), 32'h0);
    end
    step();
    check("rel0_level", 32'(level), 32'h0);
    check("rel0_pulse", 32'(release_p), 32'h1);
    check("rel0_nopress", 32'(press), 32'h0);
    step();
    check("rel0_pulse_gone", 32'(release_p), 32'h0);
    repeat (3) step();

    // bounce on channel 1: low 3, high 1, then low held
    key[1] = 1'b0;
    for (int e = 0; e < 3; e++) begin
      step();
      check("bounce_low", 32'(press), 32'h0);
    end
    key[1] = 1'b1;
    step();
    check("bounce_high", 32'(press), 32'h0);
    key[1] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("bounce_wait_press", 32'(press), 32'h0);
      check("bounce_wait_level", 32'(level), 32'h0);
    end
    step();
    check("bounce_press", 32'(press), 32'h2);
    check("bounce_level", 32'(level), 32'h2);
    key[1] = 1'b1;
    repeat (10) step();
    check("bounce_released", 32'(level), 32'h0);

    // simultaneous channels 0 and 3
    key[0] = 1'b0;
    key[3] = 1'b0;
    repeat (6) step();
    check("simul_early", 32'(press), 32'h0);
    step();
    check("simul_press", 32'(press), 32'h9);
    key[0] = 1'b1;
    key[3] = 1'b1;
    repeat (6) step();
    check("simul_rel_early", 32'(release_p), 32'h0);
    step();
    check("simul_release", 32'(release_p), 32'h9);
    check("simul_rel_nopress", 32'(press), 32'h0);
    repeat (3) step();

    // auto-repeat on channel 2 (repeat instance); non-repeat instance must stay quiet
    key[2] = 1'b0;
    repeat (7) step();
    check("rep_first_press", 32'(r_press), 32'h4);
    check("norep_first_press", 32'(press), 32'h4);
    for (int off = 1; off <= 39; off++) begin
      step();
      check("rep_pulse", 32'(r_press[2]), 32'((off >= 10) && (off % 5 == 0)));
      check("norep_quiet", 32'(press), 32'h0);
      if (off == 33) key[2] = 1'b1;
    end
    // release accepted on the same cycle a repeat would fall
    step();
    check("rep_release", 32'(r_release), 32'h4);
    check("rep_release_nopress", 32'(r_press), 32'h0);
    check("rep_level_low", 32'(r_level), 32'h0);
    check("norep_release", 32'(release_p), 32'h4);
    repeat (3) step();

    // reset mid-hold on channel 3
    key[3] = 1'b0;
    repeat (10) step();
    check("hold3_level", 32'(level), 32'h8);
    rst_n = 1'b0;
    #1;
    check("rst_async_level", 32'(level), 32'h0);
    check("rst_async_rlevel", 32'(r_level), 32'h0);
    for (int e = 0; e < 3; e++) begin
      step();
      check("rst_hold_outs", 32'({level, press, release_p}), 32'h0);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("post_rst_wait", 32'({level, press, release_p}), 32'h0);
    end
    step();
    check("post_rst_press", 32'(press), 32'h8);
    check("post_rst_level", 32'(level), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter N, default 4: number of independent pushbutton channels.
REQ-002 The block SHALL have parameter DB_CYCLES, default 250000: stable cycles required to accept a level change (5 ms at 50 MHz).
REQ-003 The block SHALL have parameter REPEAT_EN, default 0: 1 enables auto-repeat press pulses while held.
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 25000000: cycles from the accepted press to the first repeat pulse.
REQ-005 The block SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses.
REQ-006 The block SHALL have port CLOCK_50, input, width 1: the single clock; all state SHALL change on its rising edge only.
REQ-007 The block SHALL have port Resetn, input, width 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port KEY, input, width N: raw, asynchronous, active-low pushbuttons (0 = pressed).
REQ-009 The block SHALL have port key_level, output, width N: debounced state, active-high (1 = pressed).
REQ-010 The block SHALL have port key_press, output, width N: one-cycle pulse on an accepted press and on each repeat.
REQ-011 The block SHALL have port key_release, output, width N: one-cycle pulse on an accepted release.

Function
REQ-012 Each channel SHALL pass KEY[i] through a two-flop synchronizer; only the second-flop output (s[i]) SHALL feed the FSM.
REQ-013 Each channel SHALL run an independent FSM with states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE, plus a debounce counter of width clog2(DB_CYCLES+1).
- IDLE: s=0 -> WAIT_PRESS and clear the counter.
- WAIT_PRESS: s=0 -> increment; s=1 -> IDLE and clear; count==DB_CYCLES-1 with s=0 -> PRESSED.
REQ-014 PRESSED and WAIT_RELEASE SHALL mirror IDLE and WAIT_PRESS with s=1 as the changing level.
- WAIT_RELEASE: s=0 -> PRESSED and clear; count==DB_CYCLES-1 with s=1 -> IDLE.
REQ-015 key_level[i] SHALL be a registered output equal to 1 exactly when the FSM is in PRESSED or WAIT_RELEASE.
REQ-016 key_press[i] SHALL be high for exactly one cycle: the first cycle key_level[i] is 1 after WAIT_PRESS->PRESSED.
REQ-017 key_release[i] SHALL be high for exactly one cycle: the first cycle key_level[i] is 0 after WAIT_RELEASE->IDLE.
REQ-018 Latency SHALL be as follows.
- KEY[i] held low: key_level[i] and key_press[i] rise on rising edge DB_CYCLES+3 after the first edge sampling KEY[i]=0.
- KEY[i] held high: release latency SHALL be the same.
REQ-019 Any opposite-level sample of s during WAIT_* SHALL abort the transition, restart the counter from 0, and produce no pulse.
REQ-020 Auto-repeat (REPEAT_EN=1) SHALL operate as follows.
- A per-channel repeat counter SHALL clear on entry to PRESSED.
- The counter SHALL count while in PRESSED or WAIT_RELEASE.
- key_press SHALL pulse REPEAT_DELAY cycles after the accepted-press pulse, then every REPEAT_PERIOD cycles.
REQ-021 When REPEAT_EN=0, the repeat counter SHALL be absent or held at 0, and no repeat pulses SHALL occur.
REQ-022 Repeat pulses SHALL stop immediately on entry to IDLE; if a repeat falls on the release-accept cycle, only key_release SHALL pulse.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-024 key_press[i] and key_release[i] SHALL never be high in the same cycle.
REQ-025 The counters SHALL never wrap; each SHALL clear at its terminal count or on a state change.

Reset
REQ-026 Resetn=0 SHALL immediately, without waiting for a clock edge, apply all of the following.
- Synchronizer flops to 1.
- All FSMs to IDLE and all counters to 0.
- key_level, key_press and key_release to 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard all progress, with no pulse on assertion or deassertion.
REQ-028 A key still held after Resetn rises SHALL be re-debounced from IDLE with the full REQ-018 latency.

Verification
Bench parameters: N=4, DB_CYCLES=4, REPEAT_PERIOD=5, REPEAT_DELAY=10; REPEAT_EN=0 unless stated.
REQ-029 Clean press: KEY[0] 1->0 and held -> key_level[0] and a single key_press[0] at edge 7; other channels stay 0.
REQ-030 Bounce: KEY[1] low 3 cycles, high 1, then low held -> no pulse during the bounce; key_press[1] 7 edges after the final fall.
REQ-031 Release: KEY[0] 0->1 after a press -> key_level[0] falls and key_release[0] pulses once at edge 7; key_press[0] stays 0.
REQ-032 Auto-repeat: REPEAT_EN=1, KEY[2] held 30 cycles after its press pulse -> extra key_press[2] pulses at +10, +15, +20, +25 and +30.
REQ-033 Reset mid-hold: Resetn=0 for 3 cycles while KEY[3] is held pressed.
- During reset: all outputs 0 asynchronously.
- After reset: key_press[3] 7 edges after Resetn rises.
REQ-034 Simultaneous: KEY[0] and KEY[3] fall on the same edge -> both key_press bits pulse in the same cycle.
